// File: rtl/add_pkg.sv
// Shared definitions for the add/sub datapath: op-mode encoding and overflow helper.
// Latency: none (package only).
// Backpressure: not applicable.
package add_pkg;

  // Op-mode encoding carried on the 'sub' input.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Signed overflow: carry into the MSB disagrees with carry out of the MSB.
  function automatic logic ovf_f(input logic c_in_msb, input logic c_out);
    return c_in_msb ^ c_out;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder segment built from full-adder cells.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage owns flow control.
//
// Ports:
//   a, b      segment operands
//   ci        carry into bit 0
//   s         segment sum
//   co        carry out of the segment MSB
//   c_msb_in  carry into the segment MSB (used for signed overflow in the top stage)
module rca_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor; each stage ripples one SEG-bit segment.
// Latency: STAGES cycles from accept to out_valid; throughput 1 op/cycle.
// Backpressure: combinational ready chain from out_ready; stalled stages hold their data.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b, cin, sub captured on accept)
//   a, b, cin, sub       operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result, MSB carry-out (sub: 1 = no borrow), signed overflow
module rca_pipe_addsub
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  // Per-stage state: valid, partially-built result (low bits = sum so far,
  // high bits = pending operand A), operand B' and the registered carry.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c;
  logic [WIDTH-1:0]  acc [STAGES];
  logic [WIDTH-1:0]  bq  [STAGES];
  logic              ovf_q;

  // Per-stage combinational view of what the stage would capture.
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] pv;
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] co;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  nxt_acc [STAGES];
  logic [SEG-1:0]    s       [STAGES];
  logic              cm      [STAGES];

  // Subtraction is a + ~b + 1: invert B once at entry and force carry-in.
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  assign b_in = (sub == SUB) ? ~b : b;
  assign c_in = (sub == ADD) ? cin : 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_a[k] = a;
      assign src_b[k] = b_in;
      assign src_c[k] = c_in;
      assign pv[k]    = in_valid;
    end else begin : g_next
      assign src_a[k] = acc[k-1];
      assign src_b[k] = bq[k-1];
      assign src_c[k] = c[k-1];
      assign pv[k]    = v[k-1];
    end

    if (k == STAGES-1) begin : g_last_rdy
      assign rdy[k] = !v[k] || out_ready;
    end else begin : g_mid_rdy
      assign rdy[k] = !v[k] || rdy[k+1];
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a        (src_a[k][k*SEG +: SEG]),
      .b        (src_b[k][k*SEG +: SEG]),
      .ci       (src_c[k]),
      .s        (s[k]),
      .co       (co[k]),
      .c_msb_in (cm[k])
    );

    // Replace segment k of the incoming word with its freshly rippled sum.
    assign nxt_acc[k] = (src_a[k] & ~(WIDTH'({SEG{1'b1}}) << (k*SEG)))
                      | (WIDTH'(s[k]) << (k*SEG));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v     <= '0;
      c     <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc[k] <= '0;
        bq[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k] <= pv[k];
          // Data moves only with a real beat so idle outputs keep their last value.
          if (pv[k]) begin
            acc[k] <= nxt_acc[k];
            bq[k]  <= src_b[k];
            c[k]   <= co[k];
          end
        end
      end
      if (rdy[STAGES-1] && pv[STAGES-1]) begin
        ovf_q <= ovf_f(cm[STAGES-1], co[STAGES-1]);
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES-1];
  assign sum       = acc[STAGES-1];
  assign cout      = c[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub (WIDTH=8; STAGES=2 main, 1 and 8 for random).
// Latency: checks STAGES-cycle latency under no stall.
// Backpressure: exercises stall, release, reset flush and random out_ready.
module tb_rca_pipe_addsub;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  logic       rvld, rordy, rcin, rsub;
  logic [7:0] ra, rb;
  logic       ir1, ov1, co1, of1, ir8, ov8, co8, of8;
  logic [7:0] s1, s8;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_on  = 0;
  int acc1    = 0;
  int acc8    = 0;
  logic [9:0] q1[$];
  logic [9:0] q8[$];

  rca_pipe_addsub #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  rca_pipe_addsub #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(rvld), .in_ready(ir1),
    .a(ra), .b(rb), .cin(rcin), .sub(rsub), .out_valid(ov1),
    .out_ready(rordy), .sum(s1), .cout(co1), .ovf(of1)
  );

  rca_pipe_addsub #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(rvld), .in_ready(ir8),
    .a(ra), .b(rb), .cin(rcin), .sub(rsub), .out_valid(ov8),
    .out_ready(rordy), .sum(s8), .cout(co8), .ovf(of8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: {cout, ovf, sum} from 9-bit arithmetic and sign rules.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic s);
    logic [8:0] f;
    logic       o;
    if (s) begin
      f = {1'b0, x} + {1'b0, ~y} + 9'd1;
      o = (x[7] != y[7]) && (f[7] != x[7]);
    end else begin
      f = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      o = (x[7] == y[7]) && (f[7] != x[7]);
    end
    return {f[8], o, f[7:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty main pipeline; returns result and cycles to out_valid.
  task automatic run_one(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic ts, output logic [9:0] res, output int lat);
    cyc();
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    lat = 1;
    res = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        res = {cout, ovf, sum};
        break;
      end
      cyc();
      lat++;
    end
  endtask

  // Scoreboards for the STAGES=1 and STAGES=8 instances (pop before push).
  always @(negedge clk) begin
    if (rnd_on) begin
      if (ov1 && rordy) begin
        if (q1.size() == 0) chk("rnd_s1_extra_result", 0, 1);
        else chk("rnd_s1_result", {22'd0, co1, of1, s1}, {22'd0, q1.pop_front()});
      end
      if (ov8 && rordy) begin
        if (q8.size() == 0) chk("rnd_s8_extra_result", 0, 1);
        else chk("rnd_s8_result", {22'd0, co8, of8, s8}, {22'd0, q8.pop_front()});
      end
      if (rvld && ir1) begin q1.push_back(model(ra, rb, rcin, rsub)); acc1++; end
      if (rvld && ir8) begin q8.push_back(model(ra, rb, rcin, rsub)); acc8++; end
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  initial begin
    vec_t       tbl[10];
    logic [9:0] res;
    int         lat, acc, got, bad, lat1, lat8;
    logic [7:0] ta[10], tb[10];
    logic       tc[10], ts[10];
    logic [9:0] ex[10];

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[2] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
    tbl[5] = '{8'h12, 8'h34, 1'b1, 1'b1, 8'hDE, 1'b0, 1'b0};
    tbl[6] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rvld = 1'b0; rordy = 1'b0; ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_in_ready", in_ready, 1);

    // Directed single beats with hand-computed results and latency.
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, res, lat);
      chk($sformatf("vec%0d_result", i), {22'd0, res}, {22'd0, tbl[i].co, tbl[i].ov, tbl[i].s});
      chk($sformatf("vec%0d_latency", i), lat, 2);
    end

    // Ten back-to-back beats: consecutive in-order results, in_ready held high.
    for (int i = 0; i < 10; i++) begin
      ta[i] = 8'(i * 37 + 5); tb[i] = 8'(i * 91 + 200);
      tc[i] = i[0]; ts[i] = i[1];
      ex[i] = model(ta[i], tb[i], tc[i], ts[i]);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      cyc();
      if (t < 10) begin
        a = ta[t]; b = tb[t]; cin = tc[t]; sub = ts[t]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (t < 10) chk("b2b_in_ready", in_ready, 1);
      if (t >= 2) begin
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_result", {22'd0, cout, ovf, sum}, {22'd0, ex[t-2]});
      end
    end

    // Stall with three beats offered: two accepted, outputs held.
    cyc();
    out_ready = 1'b0;
    acc = 0;
    a = ta[3]; b = tb[3]; cin = tc[3]; sub = ts[3]; in_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (in_ready) acc++;
      if (t >= 3) chk("stall_hold", {22'd0, cout, ovf, sum}, {22'd0, ex[3]});
      cyc();
      if (acc < 3) begin
        a = ta[3+acc]; b = tb[3+acc]; cin = tc[3+acc]; sub = ts[3+acc];
      end
    end
    chk("stall_accepted", acc, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid) begin
        if (got < 3) chk("release_order", {22'd0, cout, ovf, sum}, {22'd0, ex[3+got]});
        got++;
      end
      if (in_valid && in_ready) acc++;
      cyc();
      if (acc < 3) begin
        a = ta[3+acc]; b = tb[3+acc]; cin = tc[3+acc]; sub = ts[3+acc];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("release_count", got, 3);

    // Reset with two beats in flight: flushed, never reappear.
    cyc();
    out_ready = 1'b0;
    a = 8'hC0; b = 8'hC0; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    cyc();
    a = 8'h33; b = 8'h44;
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sum", sum, 0);
    chk("flush_cout", cout, 0);
    chk("flush_ovf", ovf, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (out_valid) bad++;
      cyc();
    end
    chk("flush_no_ghost", bad, 0);
    run_one(8'h01, 8'h02, 1'b0, 1'b0, res, lat);
    chk("post_reset_result", {22'd0, res}, {22'd0, 10'h003});
    chk("post_reset_latency", lat, 2);

    // Latency of the STAGES=1 and STAGES=8 instances.
    cyc();
    ra = 8'h03; rb = 8'h04; rcin = 1'b0; rsub = 1'b0; rvld = 1'b1; rordy = 1'b1;
    cyc();
    rvld = 1'b0;
    lat1 = 0; lat8 = 0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (ov1 && lat1 == 0) lat1 = t;
      if (ov8 && lat8 == 0) lat8 = t;
      cyc();
    end
    chk("s1_latency", lat1, 1);
    chk("s8_latency", lat8, 8);

    // Random add/sub with random backpressure against the reference model.
    rnd_on = 1'b1;
    for (int t = 0; t < 8000; t++) begin
      cyc();
      ra = 8'($urandom); rb = 8'($urandom);
      rcin = 1'($urandom); rsub = 1'($urandom);
      rvld = ($urandom_range(0, 9) < 8);
      rordy = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      #1;
      if (acc1 >= 1000 && acc8 >= 1000) break;
    end
    cyc();
    rvld = 1'b0; rordy = 1'b1;
    for (int t = 0; t < 15; t++) cyc();
    rnd_on = 1'b0;
    chk("rnd_s1_beats", (acc1 >= 1000), 1);
    chk("rnd_s8_beats", (acc8 >= 1000), 1);
    chk("rnd_s1_drained", q1.size(), 0);
    chk("rnd_s8_drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
